fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 101 ++++++++++
 tb/tb_fifo_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller: drives the write strobe and the addresses of an external
// storage array, and tracks occupancy, threshold flags and sticky overflow/underflow errors.
module fifo_ctrl #(
  parameter int unsigned addr_width = 2,
  parameter int unsigned af_level   = 2 ** addr_width - 1,
  parameter int unsigned ae_level   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr,
  output logic                  wr_en,
  output logic [addr_width-1:0] push_addr,
  output logic [addr_width-1:0] pop_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** addr_width;
  localparam logic [addr_width:0]   DepthCnt = (addr_width + 1)'(Depth);
  localparam logic [addr_width:0]   AfCnt    = (addr_width + 1)'(af_level);
  localparam logic [addr_width:0]   AeCnt    = (addr_width + 1)'(ae_level);
  localparam logic [addr_width:0]   CntOne   = (addr_width + 1)'(1);
  localparam logic [addr_width-1:0] PtrOne   = addr_width'(1);

  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_ok, push_ok;

  // Flags are pure decodes of the registered state.
  always_comb begin
    full         = (count_q == DepthCnt);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfCnt);
    almost_empty = (count_q <= AeCnt);
    count        = count_q;
    push_addr    = wr_ptr_q;
    pop_addr     = rd_ptr_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
  always_comb begin
    rd_ok   = rd & ~empty;
    push_ok = wr & (~full | rd_ok);
    wr_en   = push_ok & ~clr & ~reset;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_ok)   rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push_ok, rd_ok})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q | (wr & ~push_ok);
      // A pop on empty alongside an accepted push is not an error.
      underflow_d = underflow_q | (rd & empty & ~push_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (addr_width=2, default thresholds): directed vectors feed an expectation
// queue, and a negedge monitor pops and compares each cycle's observed outputs.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       wr;
  logic       rd;
  logic       clr;
  logic       wr_en;
  logic [1:0] push_addr;
  logic [1:0] pop_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  typedef struct {
    int         idx;
    logic       we;
    logic [1:0] pa;
    logic [1:0] pp;
    logic [2:0] cnt;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_idx = 0;

  fifo_ctrl #(
    .addr_width(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .rd          (rd),
    .clr         (clr),
    .wr_en       (wr_en),
    .push_addr   (push_addr),
    .pop_addr    (pop_addr),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, req);
    end
  endtask

  // Apply one cycle of stimulus and queue the outputs expected during that cycle.
  task automatic step(input logic r, input logic w, input logic d, input logic c,
                      input logic we, input int pa, input int pp, input int cnt,
                      input logic ov, input logic un);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r;
    wr    = w;
    rd    = d;
    clr   = c;
    e.idx = step_idx;
    e.we  = we;
    e.pa  = 2'(pa);
    e.pp  = 2'(pp);
    e.cnt = 3'(cnt);
    e.ov  = ov;
    e.un  = un;
    exp_q.push_back(e);
    step_idx++;
  endtask

  // Monitor: thresholds af=3, ae=1, depth=4.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_en",        e.idx, int'(wr_en),        int'(e.we));
        chk("push_addr",    e.idx, int'(push_addr),    int'(e.pa));
        chk("pop_addr",     e.idx, int'(pop_addr),     int'(e.pp));
        chk("count",        e.idx, int'(count),        int'(e.cnt));
        chk("full",         e.idx, int'(full),         int'(e.cnt == 3'd4));
        chk("empty",        e.idx, int'(empty),        int'(e.cnt == 3'd0));
        chk("almost_full",  e.idx, int'(almost_full),  int'(e.cnt >= 3'd3));
        chk("almost_empty", e.idx, int'(almost_empty), int'(e.cnt <= 3'd1));
        chk("overflow",     e.idx, int'(overflow),     int'(e.ov));
        chk("underflow",    e.idx, int'(underflow),    int'(e.un));
      end
    end
  end

  initial begin
    reset = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    clr   = 1'b0;
    //   rst wr rd clr | we pa pp cnt ov un
    step(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // Fill: push_addr 0..3, count 1..4
    step(0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0,   1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0,   1, 2, 0, 2, 0, 0);
    step(0, 1, 0, 0,   1, 3, 0, 3, 0, 0);
    // Push while full is rejected, overflow sticks
    step(0, 1, 0, 0,   0, 0, 0, 4, 0, 0);
    step(0, 0, 0, 0,   0, 0, 0, 4, 1, 0);
    // Simultaneous push/pop while full
    step(0, 1, 1, 0,   1, 0, 0, 4, 1, 0);
    step(0, 0, 0, 0,   0, 1, 1, 4, 1, 0);
    // Drain, then pop on empty
    step(0, 0, 1, 0,   0, 1, 1, 4, 1, 0);
    step(0, 0, 1, 0,   0, 1, 2, 3, 1, 0);
    step(0, 0, 1, 0,   0, 1, 3, 2, 1, 0);
    step(0, 0, 1, 0,   0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0,   0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0,   0, 1, 1, 0, 1, 1);
    // Push and pop while empty: only the push is taken
    step(0, 1, 1, 0,   1, 1, 1, 0, 1, 1);
    step(0, 0, 0, 0,   0, 2, 1, 1, 1, 1);
    // Flush
    step(0, 0, 0, 1,   0, 2, 1, 1, 1, 1);
    step(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // Interleaved traffic wrapping both pointers
    step(0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0,   1, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0,   1, 2, 1, 1, 0, 0);
    step(0, 1, 1, 0,   1, 3, 2, 1, 0, 0);
    step(0, 1, 1, 0,   1, 0, 3, 1, 0, 0);
    step(0, 1, 1, 0,   1, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0,   0, 2, 1, 1, 0, 0);
    step(0, 0, 0, 0,   0, 2, 2, 0, 0, 0);
    // Refill to full, overflow, pop to 3, then clr with wr
    step(0, 1, 0, 0,   1, 2, 2, 0, 0, 0);
    step(0, 1, 0, 0,   1, 3, 2, 1, 0, 0);
    step(0, 1, 0, 0,   1, 0, 2, 2, 0, 0);
    step(0, 1, 0, 0,   1, 1, 2, 3, 0, 0);
    step(0, 1, 0, 0,   0, 2, 2, 4, 0, 0);
    step(0, 0, 1, 0,   0, 2, 2, 4, 1, 0);
    step(0, 1, 0, 1,   0, 2, 3, 3, 1, 0);
    step(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // Two pushes, then reset asserted between edges with wr held high
    step(0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0,   1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("expect_queue_drained", step_idx, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
